// File: rtl/lcd_video_pkg.sv
// Shared definitions for the LCD timing/pattern generator: pattern modes,
// colour-bar table and timing total helpers.
package lcd_video_pkg;

  typedef enum logic [1:0] {
    MODE_BAR   = 2'd0,
    MODE_GRID  = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_t;

  localparam int unsigned BAR_NUM_MAX = 8;
  localparam int unsigned GRID_STEP   = 16;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Returns one full-scale flag per channel {r,g,b}; the caller widens each
  // flag to DATA_W bits so the table stays independent of channel width.
  function automatic logic [2:0] bar_colour_flags(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b111;  // white
      3'd1:    return 3'b110;  // yellow
      3'd2:    return 3'b011;  // cyan
      3'd3:    return 3'b010;  // green
      3'd4:    return 3'b101;  // magenta
      3'd5:    return 3'b100;  // red
      3'd6:    return 3'b001;  // blue
      default: return 3'b000;  // black
    endcase
  endfunction

endpackage

// File: rtl/lcd_sync_counter.sv
// Horizontal/vertical raster counters with combinational sync, data-enable
// and coordinate decode; the top registers every decoded output.
module lcd_sync_counter
  import lcd_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned H_FP     = 2,
  parameter int unsigned H_SYNC   = 41,
  parameter int unsigned H_BP     = 2,
  parameter int unsigned V_ACTIVE = 272,
  parameter int unsigned V_FP     = 2,
  parameter int unsigned V_SYNC   = 10,
  parameter int unsigned V_BP     = 2
) (
  input  logic                        pclk,
  input  logic                        rst_n,
  output logic                        h_act,
  output logic                        h_last,
  output logic                        origin,
  output logic                        de_c,
  output logic                        hs_act,
  output logic                        vs_act,
  output logic [$clog2(H_ACTIVE)-1:0] x_c,
  output logic [$clog2(V_ACTIVE)-1:0] y_c
);

  localparam int unsigned H_TOT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);
  localparam int unsigned XW    = $clog2(H_ACTIVE);
  localparam int unsigned YW    = $clog2(V_ACTIVE);

  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST_C = HW'(H_TOT - 1);
  localparam logic [HW-1:0] HS_BEG_C = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END_C = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST_C = VW'(V_TOT - 1);
  localparam logic [VW-1:0] VS_BEG_C = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END_C = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST_C) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  logic v_act;

  always_comb begin
    h_act  = (h_cnt < H_ACT_C);
    v_act  = (v_cnt < V_ACT_C);
    h_last = (h_cnt == H_LAST_C);
    origin = (h_cnt == '0) && (v_cnt == '0);
    de_c   = h_act && v_act;
    hs_act = (h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C);
    vs_act = (v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C);
    x_c    = XW'(h_cnt);
    y_c    = YW'(v_cnt);
  end

endmodule

// File: rtl/lcd_pattern_timing_gen.sv
// Parametrised LCD timing and test-pattern source: latches the pattern
// selection per frame and registers sync, enable, colour and coordinates.
module lcd_pattern_timing_gen
  import lcd_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned H_FP     = 2,
  parameter int unsigned H_SYNC   = 41,
  parameter int unsigned H_BP     = 2,
  parameter int unsigned V_ACTIVE = 272,
  parameter int unsigned V_FP     = 2,
  parameter int unsigned V_SYNC   = 10,
  parameter int unsigned V_BP     = 2,
  parameter int unsigned HS_POL   = 0,
  parameter int unsigned VS_POL   = 0,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned BAR_NUM  = 8
) (
  input  logic                        pclk,
  input  logic                        rst_n,
  input  logic [1:0]                  mode_i,
  input  logic [3*DATA_W-1:0]         solid_rgb_i,
  output logic                        hs,
  output logic                        vs,
  output logic                        de,
  output logic [DATA_W-1:0]           rgb_r,
  output logic [DATA_W-1:0]           rgb_g,
  output logic [DATA_W-1:0]           rgb_b,
  output logic [$clog2(H_ACTIVE)-1:0] x_pos,
  output logic [$clog2(V_ACTIVE)-1:0] y_pos,
  output logic                        frame_start
);

  if (BAR_NUM == 0 || BAR_NUM > BAR_NUM_MAX || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_param_check
    $error("lcd_pattern_timing_gen: BAR_NUM must be 1..8 and porch/sync widths non-zero");
  end

  localparam int unsigned XW     = $clog2(H_ACTIVE);
  localparam int unsigned YW     = $clog2(V_ACTIVE);
  localparam int unsigned BAR_W  = (BAR_NUM == 0 || H_ACTIVE < BAR_NUM) ? 1 : H_ACTIVE / BAR_NUM;
  localparam int unsigned RW     = $clog2(BAR_W + 1);
  localparam logic        HS_LVL = 1'(HS_POL);
  localparam logic        VS_LVL = 1'(VS_POL);

  localparam logic [RW-1:0] BAR_LAST_C = RW'(BAR_W - 1);
  localparam logic [2:0]    IDX_MAX_C  = 3'((BAR_NUM == 0) ? 0 : BAR_NUM - 1);

  logic          h_act, h_last, origin, de_c, hs_act, vs_act;
  logic [XW-1:0] x_c;
  logic [YW-1:0] y_c;

  lcd_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_sync_counter (
    .pclk   (pclk),
    .rst_n  (rst_n),
    .h_act  (h_act),
    .h_last (h_last),
    .origin (origin),
    .de_c   (de_c),
    .hs_act (hs_act),
    .vs_act (vs_act),
    .x_c    (x_c),
    .y_c    (y_c)
  );

  mode_t              mode_q, mode_eff;
  logic [3*DATA_W-1:0] solid_q, solid_eff;
  logic [RW-1:0]       bar_run;
  logic [2:0]          bar_idx;
  logic [2:0]          flags;
  logic                grid_on;
  logic [DATA_W-1:0]   grad;
  logic [3*DATA_W-1:0] pix;

  // The pixel at the origin already belongs to the new frame, so it uses the
  // live inputs; every later pixel of the frame uses the latched copy.
  always_comb begin
    mode_eff  = origin ? mode_t'(mode_i) : mode_q;
    solid_eff = origin ? solid_rgb_i : solid_q;
    flags     = bar_colour_flags(bar_idx);
    grid_on   = (32'(x_c) % GRID_STEP == 0) || (32'(y_c) % GRID_STEP == 0) ||
                (32'(x_c) == H_ACTIVE - 1) || (32'(y_c) == V_ACTIVE - 1);
    grad      = DATA_W'(32'(x_c));
    pix       = '0;
    case (mode_eff)
      MODE_BAR:   pix = {{DATA_W{flags[2]}}, {DATA_W{flags[1]}}, {DATA_W{flags[0]}}};
      MODE_GRID:  pix = grid_on ? '1 : '0;
      MODE_GRAD:  pix = {grad, grad, grad};
      MODE_SOLID: pix = solid_eff;
      default:    pix = '0;
    endcase
    if (!de_c) pix = '0;
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      hs          <= ~HS_LVL;
      vs          <= ~VS_LVL;
      de          <= 1'b0;
      rgb_r       <= '0;
      rgb_g       <= '0;
      rgb_b       <= '0;
      x_pos       <= '0;
      y_pos       <= '0;
      frame_start <= 1'b0;
      mode_q      <= MODE_BAR;
      solid_q     <= '0;
      bar_run     <= '0;
      bar_idx     <= '0;
    end else begin
      hs                    <= hs_act ? HS_LVL : ~HS_LVL;
      vs                    <= vs_act ? VS_LVL : ~VS_LVL;
      de                    <= de_c;
      {rgb_r, rgb_g, rgb_b} <= pix;
      x_pos                 <= de_c ? x_c : '0;
      y_pos                 <= de_c ? y_c : '0;
      frame_start           <= origin;
      if (origin) begin
        mode_q  <= mode_t'(mode_i);
        solid_q <= solid_rgb_i;
      end
      // Run counter tracks the bar of the pixel the counters point at next.
      if (h_last) begin
        bar_run <= '0;
        bar_idx <= '0;
      end else if (h_act) begin
        if (bar_run == BAR_LAST_C) begin
          bar_run <= '0;
          if (bar_idx != IDX_MAX_C) bar_idx <= bar_idx + 1'b1;
        end else begin
          bar_run <= bar_run + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_pattern_timing_gen.sv
// Directed bench for lcd_pattern_timing_gen: default panel, 7-bar variant,
// a small raster for whole-frame behaviour and an 800-wide active-high-hsync panel.
module tb_lcd_pattern_timing_gen;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // dut_a: defaults
  logic        rst_a = 1'b0;
  logic [1:0]  mode_a = 2'd0;
  logic [23:0] solid_a = 24'h0;
  logic        hs_a, vs_a, de_a, fs_a;
  logic [7:0]  r_a, g_a, b_a;
  logic [8:0]  x_a, y_a;

  lcd_pattern_timing_gen u_dut_a (
    .pclk(pclk), .rst_n(rst_a), .mode_i(mode_a), .solid_rgb_i(solid_a),
    .hs(hs_a), .vs(vs_a), .de(de_a), .rgb_r(r_a), .rgb_g(g_a), .rgb_b(b_a),
    .x_pos(x_a), .y_pos(y_a), .frame_start(fs_a)
  );

  // dut_c: defaults with seven bars (BAR_W = 68)
  logic        rst_c = 1'b0;
  logic [1:0]  mode_c = 2'd0;
  logic [23:0] solid_c = 24'h0;
  logic        hs_c, vs_c, de_c, fs_c;
  logic [7:0]  r_c, g_c, b_c;
  logic [8:0]  x_c, y_c;

  lcd_pattern_timing_gen #(.BAR_NUM(7)) u_dut_c (
    .pclk(pclk), .rst_n(rst_c), .mode_i(mode_c), .solid_rgb_i(solid_c),
    .hs(hs_c), .vs(vs_c), .de(de_c), .rgb_r(r_c), .rgb_g(g_c), .rgb_b(b_c),
    .x_pos(x_c), .y_pos(y_c), .frame_start(fs_c)
  );

  // dut_b: 32x6 raster, H_TOT = 40, V_TOT = 10, BAR_W = 4
  logic        rst_b = 1'b0;
  logic [1:0]  mode_b = 2'd0;
  logic [23:0] solid_b = 24'h0;
  logic        hs_b, vs_b, de_b, fs_b;
  logic [7:0]  r_b, g_b, b_b;
  logic [4:0]  x_b;
  logic [2:0]  y_b;

  lcd_pattern_timing_gen #(
    .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_dut_b (
    .pclk(pclk), .rst_n(rst_b), .mode_i(mode_b), .solid_rgb_i(solid_b),
    .hs(hs_b), .vs(vs_b), .de(de_b), .rgb_r(r_b), .rgb_g(g_b), .rgb_b(b_b),
    .x_pos(x_b), .y_pos(y_b), .frame_start(fs_b)
  );

  // dut_d: 800x480, active-high hsync, H_TOT = 845
  logic        rst_d = 1'b0;
  logic [1:0]  mode_d = 2'd0;
  logic [23:0] solid_d = 24'h0;
  logic        hs_d, vs_d, de_d, fs_d;
  logic [7:0]  r_d, g_d, b_d;
  logic [9:0]  x_d;
  logic [8:0]  y_d;

  lcd_pattern_timing_gen #(.H_ACTIVE(800), .V_ACTIVE(480), .HS_POL(1)) u_dut_d (
    .pclk(pclk), .rst_n(rst_d), .mode_i(mode_d), .solid_rgb_i(solid_d),
    .hs(hs_d), .vs(vs_d), .de(de_d), .rgb_r(r_d), .rgb_g(g_d), .rgb_b(b_d),
    .x_pos(x_d), .y_pos(y_d), .frame_start(fs_d)
  );

  initial begin
    int de_cnt, hs_cnt, vs_cnt, fs_cnt, blue_cnt, line_de, full_lines, blank_rgb;

    // Reset state
    repeat (3) @(negedge pclk);
    chk("rst_hs_a", hs_a, 1'b1);
    chk("rst_vs_a", vs_a, 1'b1);
    chk("rst_de_a", de_a, 1'b0);
    chk("rst_rgb_a", {r_a, g_a, b_a}, 24'h0);
    chk("rst_xy_a", {x_a, y_a}, 18'h0);
    chk("rst_fs_a", fs_a, 1'b0);
    chk("rst_hs_d", hs_d, 1'b0);

    // Line 0 of default panel in bar mode, plus the seven-bar variant
    de_cnt = 0; hs_cnt = 0; fs_cnt = 0; blue_cnt = 0;
    rst_a = 1'b1;
    rst_c = 1'b1;
    for (int t = 0; t < 525; t++) begin
      @(negedge pclk);
      de_cnt += int'(de_a);
      hs_cnt += int'(!hs_a);
      fs_cnt += int'(fs_a);
      if (t >= 408 && t <= 479 && {r_c, g_c, b_c} == 24'h0000FF) blue_cnt++;
      if (t == 0) begin
        chk("first_fs", fs_a, 1'b1);
        chk("first_de", de_a, 1'b1);
        chk("first_xy", {x_a, y_a}, 18'h0);
      end
      if (t == 59)  chk("bar_px59", {r_a, g_a, b_a}, 24'hFFFFFF);
      if (t == 60)  chk("bar_px60", {r_a, g_a, b_a}, 24'hFFFF00);
      if (t == 479) chk("bar_px479", {r_a, g_a, b_a}, 24'h000000);
      if (t == 300) chk("x_pos_300", x_a, 9'd300);
      if (t == 480) chk("blank_rgb_480", {de_a, r_a, g_a, b_a}, 25'h0);
      if (t == 407) chk("bar7_px407", {r_c, g_c, b_c}, 24'hFF0000);
    end
    chk("line_de_cnt", de_cnt, 480);
    chk("line_hs_low", hs_cnt, 41);
    chk("line_fs_cnt", fs_cnt, 1);
    chk("bar7_blue_run", blue_cnt, 72);
    @(negedge pclk);
    chk("line1_start", {de_a, fs_a, x_a, y_a}, {1'b1, 1'b0, 9'd0, 9'd1});

    // Gradient, latched through a reset
    mode_a = 2'd2;
    rst_a = 1'b0;
    @(negedge pclk);
    rst_a = 1'b1;
    for (int t = 0; t < 301; t++) begin
      @(negedge pclk);
      if (t == 255) chk("grad_255", {r_a, g_a, b_a}, 24'hFFFFFF);
      if (t == 256) chk("grad_256", {r_a, g_a, b_a}, 24'h000000);
      if (t == 300) chk("grad_300", {r_a, g_a, b_a}, 24'h2C2C2C);
    end

    // Grid on dut_a; mid-frame reset on dut_c at line 100 pixel 200
    mode_a = 2'd1;
    rst_a = 1'b0;
    rst_c = 1'b0;
    @(negedge pclk);
    rst_a = 1'b1;
    rst_c = 1'b1;
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int t = 0; t <= 100 * 525 + 479; t++) begin
      @(negedge pclk);
      if (t < 100 * 525) begin
        de_cnt += int'(de_a);
        hs_cnt += int'(!hs_a);
        vs_cnt += int'(!vs_a);
      end
      if (t == 5 * 525)        chk("grid_0_5", {r_a, g_a, b_a}, 24'hFFFFFF);
      if (t == 5 * 525)        chk("grid_xy_0_5", {x_a, y_a}, {9'd0, 9'd5});
      if (t == 17 * 525 + 17)  chk("grid_17_17", {r_a, g_a, b_a}, 24'h000000);
      if (t == 3 * 525 + 16)   chk("grid_16_3", {r_a, g_a, b_a}, 24'hFFFFFF);
      if (t == 100 * 525 + 479) chk("grid_479_100", {r_a, g_a, b_a}, 24'hFFFFFF);
      if (t == 100 * 525 + 199) begin
        chk("pre_rst_xy_c", {de_c, x_c, y_c}, {1'b1, 9'd199, 9'd100});
        rst_c = 1'b0;
      end
      if (t == 100 * 525 + 200) begin
        chk("mid_rst_sync_c", {hs_c, vs_c, de_c, fs_c}, 4'b1100);
        chk("mid_rst_data_c", {r_c, g_c, b_c, x_c, y_c}, 42'h0);
      end
      if (t == 100 * 525 + 202) begin
        chk("mid_rst_hold_c", {de_c, fs_c}, 2'b00);
        rst_c = 1'b1;
      end
      if (t == 100 * 525 + 203) begin
        chk("post_rst_fs_c", {fs_c, de_c, x_c, y_c}, {1'b1, 1'b1, 9'd0, 9'd0});
        chk("post_rst_rgb_c", {r_c, g_c, b_c}, 24'hFFFFFF);
      end
    end
    chk("100_lines_de", de_cnt, 48000);
    chk("100_lines_hs", hs_cnt, 4100);
    chk("100_lines_vs", vs_cnt, 0);

    // Small raster: two whole frames with a bar->solid switch mid-frame
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; line_de = 0; full_lines = 0; blank_rgb = 0;
    rst_b = 1'b1;
    for (int t = 0; t < 800; t++) begin
      @(negedge pclk);
      de_cnt += int'(de_b);
      hs_cnt += int'(!hs_b);
      vs_cnt += int'(!vs_b);
      fs_cnt += int'(fs_b);
      line_de += int'(de_b);
      if (!de_b && {r_b, g_b, b_b} != 24'h0) blank_rgb++;
      if (t % 40 == 39) begin
        if (line_de == 32) full_lines++;
        line_de = 0;
      end
      if (t == 27)  chk("small_bar_27", {r_b, g_b, b_b}, 24'h0000FF);
      if (t == 31)  chk("small_bar_31", {r_b, g_b, b_b}, 24'h000000);
      if (t == 200) begin
        mode_b = 2'd3;
        solid_b = 24'h123456;
      end
      if (t == 210) chk("switch_keeps_bar", {r_b, g_b, b_b}, 24'h00FFFF);
      if (t == 400) chk("solid_at_fs", {fs_b, r_b, g_b, b_b}, {1'b1, 24'h123456});
      if (t == 540) chk("solid_mid", {r_b, g_b, b_b}, 24'h123456);
      if (t == 433) chk("solid_blank", {de_b, r_b, g_b, b_b}, 25'h0);
    end
    chk("small_de_total", de_cnt, 384);
    chk("small_de_lines", full_lines, 12);
    chk("small_hs_low", hs_cnt, 80);
    chk("small_vs_low", vs_cnt, 160);
    chk("small_fs_cnt", fs_cnt, 2);
    chk("small_blank_rgb", blank_rgb, 0);

    // 800-wide panel, active-high hsync
    de_cnt = 0; hs_cnt = 0;
    rst_d = 1'b1;
    for (int t = 0; t < 845; t++) begin
      @(negedge pclk);
      de_cnt += int'(de_d);
      hs_cnt += int'(hs_d);
      if (t == 0) chk("wide_vs_idle", {vs_d, fs_d}, 2'b11);
      if (t == 799) chk("wide_x_799", x_d, 10'd799);
    end
    chk("wide_line_de", de_cnt, 800);
    chk("wide_hs_high", hs_cnt, 41);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
